uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 500000: idle clock cycles allowed between accepted bytes inside a frame.
REQ-002 SHALL have parameter ADDR_W, default 7: matrix buffer address width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rx_data  input  8  received byte from the UART.
REQ-006 SHALL have port rx_valid  input  1  rx_data valid.
REQ-007 SHALL have port rx_ready  output  1  parser can accept a byte.
REQ-008 SHALL have port tx_data  output  8  response byte to the UART.
REQ-009 SHALL have port tx_valid  output  1  tx_data valid.
REQ-010 SHALL have port tx_ready  input  1  UART can accept tx_data.
REQ-011 SHALL have port buf_wr_en  output  1  one-cycle matrix buffer write strobe.
REQ-012 SHALL have port buf_wr_sel  output  1  target matrix: 0 = A, 1 = B.
REQ-013 SHALL have port buf_wr_addr  output  ADDR_W  element address.
REQ-014 SHALL have port buf_wr_data  output  8  element value.
REQ-015 SHALL have port start  output  1  one-cycle compute start pulse.
REQ-016 SHALL have port busy  input  1  multiplier is computing.
REQ-017 SHALL have port err_count  output  8  saturating count of NAKs and timeouts.

Function
REQ-018 A byte SHALL be accepted only in a cycle with rx_valid && rx_ready.
REQ-019 Frame format: 0xA5, CMD, LEN, LEN payload bytes, CK. CK = XOR of CMD, LEN and all payload bytes.
REQ-020 States: IDLE, CMD, LEN, PAYLOAD, CHECK, RESP. rx_ready SHALL be 1 in all states except RESP.
REQ-021 IDLE: accepted 0xA5 goes to CMD. Any other byte is discarded with no other effect.
REQ-022 CMD: the accepted byte is stored as cmd, the checksum is initialised to it, and the state goes to LEN.
REQ-023 LEN: the accepted byte is stored as len and XORed into the checksum. The offset is set to 0. The next state is CHECK if len==0, otherwise PAYLOAD.
REQ-024 PAYLOAD, per accepted byte:
- XOR the byte into the checksum.
- If cmd is 0x01 or 0x02, assert buf_wr_en on the next cycle, with buf_wr_sel = (cmd==0x02), buf_wr_addr = offset[ADDR_W-1:0] (wraps modulo 2^ADDR_W), and buf_wr_data = the byte.
- Increment the offset.
- After len bytes, go to CHECK.
REQ-025 Payload writes SHALL occur even if the checksum later fails. No writes SHALL occur for any other cmd.
REQ-026 CHECK: the accepted byte is compared with the checksum. The response SHALL be ACK (0x06) iff CK matches, cmd is in {0x01, 0x02, 0x03}, and not (cmd==0x03 && busy). Otherwise the response SHALL be NAK (0x15).
REQ-027 On ACK for cmd 0x03, start SHALL pulse for exactly one cycle, on the cycle after the CK byte is accepted.
REQ-028 RESP: tx_valid=1 and tx_data SHALL hold stable until tx_valid && tx_ready, then the state returns to IDLE. tx_valid deasserts the following cycle.
REQ-029 On NAK, err_count SHALL increment once (saturating at 255).
REQ-030 Timeout:
- In CMD, LEN, PAYLOAD and CHECK, an idle counter SHALL clear on every accepted byte.
- When the counter reaches TIMEOUT_CYCLES-1, the state SHALL return to IDLE with no response and err_count SHALL increment (saturating).
- The counter SHALL be inactive in IDLE and RESP.
REQ-031 A byte accepted in the same cycle as timeout expiry SHALL be discarded; timeout takes priority.

Reset
REQ-032 With rst high at a clock edge, the block SHALL return to IDLE from any state, discard any partial frame, and drop any pending response.
REQ-033 Values on the cycle after reset: rx_ready=1; tx_valid=0; tx_data=0x00; buf_wr_en=0; buf_wr_sel=0; buf_wr_addr=0; buf_wr_data=0x00; start=0; err_count=0; all internal counters 0.

Verification
REQ-034 Send A5 01 03 11 22 33 02 -> writes A[0]=0x11, A[1]=0x22, A[2]=0x33, one strobe each; tx 0x06; err_count=0.
REQ-035 Send A5 02 01 7F 00 (correct CK is 0x7C) -> write B[0]=0x7F occurs; tx 0x15; err_count=1.
REQ-036 Send A5 03 00 03 with busy=0 -> tx 0x06 and a single-cycle start pulse. Repeat with busy=1 -> tx 0x15, no start.
REQ-037 Send 00 FF A5 01 then idle for TIMEOUT_CYCLES -> no tx, no writes, err_count=1. A following valid frame SHALL still get 0x06.
REQ-038 Hold tx_ready=0 for 20 cycles in RESP while rx_valid=1 -> tx_valid and tx_data stable, rx_ready=0, no bytes accepted.
REQ-039 Assert rst in the middle of the payload of a LOAD_A frame -> all outputs at reset values on the next cycle, no response, and the next frame is parsed from IDLE.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// UART command parser: receives framed commands (A5, CMD, LEN, payload, CK),
// streams LOAD_A/LOAD_B payload into the matrix buffers, issues the compute
// start pulse and answers each complete frame with ACK or NAK.
module uart_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int ADDR_W         = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              buf_wr_en,
  output logic              buf_wr_sel,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [7:0]        buf_wr_data,
  output logic              start,
  input  logic              busy,
  output logic [7:0]        err_count
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] SOF        = 8'hA5;
  localparam logic [7:0] ACK        = 8'h06;
  localparam logic [7:0] NAK        = 8'h15;
  localparam logic [7:0] CMD_LOAD_A = 8'h01;
  localparam logic [7:0] CMD_LOAD_B = 8'h02;
  localparam logic [7:0] CMD_START  = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHECK   = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  // Running frame checksum: XOR fold of one more byte.
  function automatic logic [7:0] ck_fold(input logic [7:0] ck, input logic [7:0] b);
    return ck ^ b;
  endfunction

  // Error counter increment that sticks at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_cmd;
  logic [7:0]       r_len;
  logic [7:0]       r_ck;
  logic [7:0]       r_off;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [7:0]       r_tx_data;
  logic             r_wr_en;
  logic             r_wr_sel;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]       r_wr_data;
  logic             r_start;
  logic [7:0]       r_err;

  logic w_rx_ready;
  logic w_cnt_active;
  logic w_timeout;
  logic w_accept;
  logic w_last;
  logic w_is_load;
  logic w_ack;

  assign w_rx_ready   = (r_state != S_RESP);
  assign w_cnt_active = (r_state == S_CMD) || (r_state == S_LEN) ||
                        (r_state == S_PAYLOAD) || (r_state == S_CHECK);
  // Timeout wins over a byte arriving in the same cycle.
  assign w_timeout    = w_cnt_active && (r_idle_cnt == CNT_LAST);
  assign w_accept     = rx_valid && w_rx_ready && !w_timeout;
  assign w_last       = ((r_off + 8'd1) == r_len);
  assign w_is_load    = (r_cmd == CMD_LOAD_A) || (r_cmd == CMD_LOAD_B);
  assign w_ack        = (rx_data == r_ck) &&
                        (w_is_load || (r_cmd == CMD_START)) &&
                        !((r_cmd == CMD_START) && busy);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic for the frame parser.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (rx_data == SOF)) begin
          w_state_nxt = S_CMD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CMD: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end else if (w_accept) begin
          w_state_nxt = S_LEN;
        end else begin
          w_state_nxt = S_CMD;
        end
      end
      S_LEN: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end else if (w_accept) begin
          w_state_nxt = (rx_data == 8'h00) ? S_CHECK : S_PAYLOAD;
        end else begin
          w_state_nxt = S_LEN;
        end
      end
      S_PAYLOAD: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end else if (w_accept && w_last) begin
          w_state_nxt = S_CHECK;
        end else begin
          w_state_nxt = S_PAYLOAD;
        end
      end
      S_CHECK: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end else if (w_accept) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_CHECK;
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame datapath: header capture, checksum, buffer writes, response and errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd      <= 8'h00;
      r_len      <= 8'h00;
      r_ck       <= 8'h00;
      r_off      <= 8'h00;
      r_idle_cnt <= {CNT_W{1'b0}};
      r_tx_data  <= 8'h00;
      r_wr_en    <= 1'b0;
      r_wr_sel   <= 1'b0;
      r_wr_addr  <= {ADDR_W{1'b0}};
      r_wr_data  <= 8'h00;
      r_start    <= 1'b0;
      r_err      <= 8'h00;
    end else begin
      r_wr_en <= 1'b0;
      r_start <= 1'b0;
      if (w_cnt_active && !w_timeout && !w_accept) begin
        r_idle_cnt <= r_idle_cnt + CNT_W'(1);
      end else begin
        r_idle_cnt <= {CNT_W{1'b0}};
      end
      if (w_timeout) begin
        r_err <= sat_inc(r_err);
      end else if (w_accept) begin
        case (r_state)
          S_CMD: begin
            r_cmd <= rx_data;
            r_ck  <= rx_data;
          end
          S_LEN: begin
            r_len <= rx_data;
            r_ck  <= ck_fold(r_ck, rx_data);
            r_off <= 8'h00;
          end
          S_PAYLOAD: begin
            r_ck  <= ck_fold(r_ck, rx_data);
            r_off <= r_off + 8'd1;
            if (w_is_load) begin
              r_wr_en   <= 1'b1;
              r_wr_sel  <= (r_cmd == CMD_LOAD_B);
              r_wr_addr <= ADDR_W'(r_off);
              r_wr_data <= rx_data;
            end
          end
          S_CHECK: begin
            r_tx_data <= w_ack ? ACK : NAK;
            if (w_ack && (r_cmd == CMD_START)) begin
              r_start <= 1'b1;
            end
            if (!w_ack) begin
              r_err <= sat_inc(r_err);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign rx_ready    = w_rx_ready;
  assign tx_valid    = (r_state == S_RESP);
  assign tx_data     = r_tx_data;
  assign buf_wr_en   = r_wr_en;
  assign buf_wr_sel  = r_wr_sel;
  assign buf_wr_addr = r_wr_addr;
  assign buf_wr_data = r_wr_data;
  assign start       = r_start;
  assign err_count   = r_err;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with hand-computed frames and checksums.
module tb_uart_cmd_parser;
  localparam int T  = 16;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          buf_wr_en;
  logic          buf_wr_sel;
  logic [AW-1:0] buf_wr_addr;
  logic [7:0]    buf_wr_data;
  logic          start;
  logic          busy;
  logic [7:0]    err_count;

  int checks   = 0;
  int failures = 0;

  // Event logs recorded by the monitor, never cleared; tests work on deltas.
  logic          wr_sel_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [7:0]    wr_data_q[$];
  logic [7:0]    tx_q[$];
  int            start_cnt = 0;

  uart_cmd_parser #(.TIMEOUT_CYCLES(T), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .buf_wr_en(buf_wr_en), .buf_wr_sel(buf_wr_sel), .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data), .start(start), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Monitor: record strobes and handshakes mid-cycle.
  always @(negedge clk) begin
    if (buf_wr_en === 1'b1) begin
      wr_sel_q.push_back(buf_wr_sel);
      wr_addr_q.push_back(buf_wr_addr);
      wr_data_q.push_back(buf_wr_data);
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_q.push_back(tx_data);
    if (start === 1'b1) start_cnt = start_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done     = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (rx_ready === 1'b1) begin
        done = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_timeout byte=%02h: got rx_ready never high, want accept within 50 cycles", b);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1; busy = 1'b0;
    tick(2);
    rst = 1'b0;
    checks++;
    if ({rx_ready, tx_valid, buf_wr_en, buf_wr_sel, start} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags: got rdy/txv/wen/sel/start=%b, want 10000",
               {rx_ready, tx_valid, buf_wr_en, buf_wr_sel, start});
    end
    checks++;
    if (tx_data !== 8'h00 || buf_wr_data !== 8'h00 || buf_wr_addr !== 7'd0) begin
      failures++;
      $display("FAIL reset_data: got tx=%h wdata=%h waddr=%h, want 00 00 00",
               tx_data, buf_wr_data, buf_wr_addr);
    end
    checks++;
    if (err_count !== 8'h00) begin
      failures++;
      $display("FAIL reset_err: got %h, want 00", err_count);
    end
  endtask

  task automatic test_load_a;
    logic [7:0] exp_d[3];
    int wb, tb;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    wb = wr_data_q.size(); tb = tx_q.size();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h02);
    tick(4);
    checks++;
    if (wr_data_q.size() - wb !== 3) begin
      failures++;
      $display("FAIL load_a_count: got %0d writes, want 3", wr_data_q.size() - wb);
    end
    for (int i = 0; i < 3; i++) begin
      if (wr_data_q.size() > wb + i) begin
        checks++;
        if (wr_sel_q[wb+i] !== 1'b0 || wr_addr_q[wb+i] !== 7'(i) || wr_data_q[wb+i] !== exp_d[i]) begin
          failures++;
          $display("FAIL load_a_write%0d: got sel=%b addr=%h data=%h, want 0 %h %h",
                   i, wr_sel_q[wb+i], wr_addr_q[wb+i], wr_data_q[wb+i], 7'(i), exp_d[i]);
        end
      end
    end
    checks++;
    if (tx_q.size() - tb !== 1 || (tx_q.size() > tb && tx_q[tb] !== 8'h06)) begin
      failures++;
      $display("FAIL load_a_resp: got %0d responses, want one 06", tx_q.size() - tb);
    end
    checks++;
    if (err_count !== 8'h00) begin
      failures++;
      $display("FAIL load_a_err: got %h, want 00", err_count);
    end
  endtask

  task automatic test_nak_load_b;
    int wb, tb;
    wb = wr_data_q.size(); tb = tx_q.size();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h00);
    tick(4);
    checks++;
    if (wr_data_q.size() - wb !== 1 ||
        (wr_data_q.size() > wb && (wr_sel_q[wb] !== 1'b1 || wr_addr_q[wb] !== 7'd0 || wr_data_q[wb] !== 8'h7F))) begin
      failures++;
      $display("FAIL nak_b_write: got %0d writes, want one B[0]=7F", wr_data_q.size() - wb);
    end
    checks++;
    if (tx_q.size() - tb !== 1 || (tx_q.size() > tb && tx_q[tb] !== 8'h15)) begin
      failures++;
      $display("FAIL nak_b_resp: got %0d responses, want one 15", tx_q.size() - tb);
    end
    checks++;
    if (err_count !== 8'h01) begin
      failures++;
      $display("FAIL nak_b_err: got %h, want 01", err_count);
    end
  endtask

  task automatic test_start;
    int tb, sb;
    busy = 1'b0;
    tb = tx_q.size(); sb = start_cnt;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00); send_byte(8'h03);
    checks++;
    if (start !== 1'b1) begin
      failures++;
      $display("FAIL start_pulse: got start=%b after CK, want 1", start);
    end
    tick(1);
    checks++;
    if (start !== 1'b0) begin
      failures++;
      $display("FAIL start_width: got start=%b one cycle later, want 0", start);
    end
    tick(3);
    checks++;
    if (tx_q.size() - tb !== 1 || (tx_q.size() > tb && tx_q[tb] !== 8'h06) || start_cnt - sb !== 1) begin
      failures++;
      $display("FAIL start_ack: got %0d responses %0d pulses, want one 06 and 1 pulse",
               tx_q.size() - tb, start_cnt - sb);
    end
    busy = 1'b1;
    tb = tx_q.size(); sb = start_cnt;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00); send_byte(8'h03);
    tick(4);
    busy = 1'b0;
    checks++;
    if (tx_q.size() - tb !== 1 || (tx_q.size() > tb && tx_q[tb] !== 8'h15) || start_cnt - sb !== 0) begin
      failures++;
      $display("FAIL start_busy: got %0d responses %0d pulses, want one 15 and 0 pulses",
               tx_q.size() - tb, start_cnt - sb);
    end
    checks++;
    if (err_count !== 8'h02) begin
      failures++;
      $display("FAIL start_busy_err: got %h, want 02", err_count);
    end
  endtask

  task automatic test_other_cmd;
    int wb, tb;
    wb = wr_data_q.size(); tb = tx_q.size();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'h05);
    tick(4);
    checks++;
    if (wr_data_q.size() - wb !== 0 || tx_q.size() - tb !== 1 || (tx_q.size() > tb && tx_q[tb] !== 8'h15)) begin
      failures++;
      $display("FAIL other_cmd: got %0d writes %0d responses, want 0 writes and one 15",
               wr_data_q.size() - wb, tx_q.size() - tb);
    end
  endtask

  task automatic test_timeout;
    int wb, tb, sb;
    rst = 1'b1; tick(1); rst = 1'b0;
    wb = wr_data_q.size(); tb = tx_q.size();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5); send_byte(8'h01);
    tick(T - 1);
    checks++;
    if (err_count !== 8'h00) begin
      failures++;
      $display("FAIL timeout_early: got err=%h one cycle before expiry, want 00", err_count);
    end
    tick(1);
    checks++;
    if (err_count !== 8'h01) begin
      failures++;
      $display("FAIL timeout_err: got err=%h at expiry, want 01", err_count);
    end
    tick(3);
    checks++;
    if (wr_data_q.size() - wb !== 0 || tx_q.size() - tb !== 0) begin
      failures++;
      $display("FAIL timeout_quiet: got %0d writes %0d responses, want 0 0",
               wr_data_q.size() - wb, tx_q.size() - tb);
    end
    tb = tx_q.size();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h44); send_byte(8'h44);
    tick(4);
    checks++;
    if (tx_q.size() - tb !== 1 || (tx_q.size() > tb && tx_q[tb] !== 8'h06)) begin
      failures++;
      $display("FAIL timeout_recover: got %0d responses, want one 06", tx_q.size() - tb);
    end
    // A byte landing on the expiry cycle must be dropped.
    tb = tx_q.size(); sb = start_cnt;
    send_byte(8'hA5); send_byte(8'h03);
    tick(T - 1);
    send_byte(8'h00);
    send_byte(8'h03);
    tick(4);
    checks++;
    if (tx_q.size() - tb !== 0 || start_cnt - sb !== 0 || err_count !== 8'h02) begin
      failures++;
      $display("FAIL timeout_priority: got %0d responses %0d pulses err=%h, want 0 0 02",
               tx_q.size() - tb, start_cnt - sb, err_count);
    end
  endtask

  task automatic test_backpressure;
    int tb;
    tb = tx_q.size();
    tx_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00); send_byte(8'h03);
    rx_data = 8'hA5; rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h06 || rx_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: got txv=%b tx=%h rdy=%b, want 1 06 0",
                 i, tx_valid, tx_data, rx_ready);
      end
      tick(1);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    tick(1);
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: got txv=%b rdy=%b, want 0 1", tx_valid, rx_ready);
    end
    tick(2);
    checks++;
    if (tx_q.size() - tb !== 1) begin
      failures++;
      $display("FAIL hold_count: got %0d responses, want 1", tx_q.size() - tb);
    end
  endtask

  task automatic test_reset_mid;
    int wb, tb;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05); send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({rx_ready, tx_valid, buf_wr_en, buf_wr_sel, start} !== 5'b10000 ||
        tx_data !== 8'h00 || buf_wr_data !== 8'h00 || buf_wr_addr !== 7'd0 || err_count !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_outputs: got flags=%b tx=%h wd=%h wa=%h err=%h, want 10000 00 00 00 00",
               {rx_ready, tx_valid, buf_wr_en, buf_wr_sel, start}, tx_data, buf_wr_data, buf_wr_addr, err_count);
    end
    wb = wr_data_q.size(); tb = tx_q.size();
    tick(3);
    checks++;
    if (tx_q.size() - tb !== 0) begin
      failures++;
      $display("FAIL reset_mid_resp: got %0d responses, want 0", tx_q.size() - tb);
    end
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    tick(4);
    checks++;
    if (wr_data_q.size() - wb !== 2 ||
        (wr_data_q.size() > wb + 1 &&
         (wr_sel_q[wb] !== 1'b1 || wr_addr_q[wb] !== 7'd0 || wr_data_q[wb] !== 8'h10 ||
          wr_sel_q[wb+1] !== 1'b1 || wr_addr_q[wb+1] !== 7'd1 || wr_data_q[wb+1] !== 8'h20))) begin
      failures++;
      $display("FAIL reset_mid_writes: got %0d writes, want B[0]=10 B[1]=20", wr_data_q.size() - wb);
    end
    checks++;
    if (tx_q.size() - tb !== 1 || (tx_q.size() > tb && tx_q[tb] !== 8'h06)) begin
      failures++;
      $display("FAIL reset_mid_ack: got %0d responses, want one 06", tx_q.size() - tb);
    end
  endtask

  initial begin
    test_reset();
    test_load_a();
    test_nak_load_b();
    test_start();
    test_other_cmd();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
